complement_unit_seq: RTL



---
 rtl/complement_unit_seq_pkg.sv | 15 +
 rtl/complement_unit_seq_if.sv | 22 ++
 rtl/complement_unit_seq_chunk.sv | 19 +
 rtl/complement_unit_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/complement_unit_seq_pkg.sv
// Shared constants for the sequential complement unit: mode codes and FSM states.
package complement_pkg;

  localparam logic [1:0] MODE_NOT  = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/complement_unit_seq_if.sv
// Operand/result handshake bundle for the complement unit.
interface complement_unit_seq_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, y, zero, ovf
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, y, zero, ovf
  );
endinterface

// File: rtl/complement_unit_seq_chunk.sv
// One CHUNK-bit slice: optional inversion followed by a carry-in increment.
module complement_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] x,
  input  logic             inv,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK-1:0] xi;

  assign xi = inv ? ~x : x;

  // Increment-by-carry; the top bit of the sum becomes the ripple carry.
  always_comb begin
    {cout, s} = {1'b0, xi} + {{CHUNK{1'b0}}, cin};
  end
endmodule

// File: rtl/complement_unit_seq.sv
// Multi-cycle NOT / NEG / ABS / PASS unit, one CHUNK slice per cycle LSB-first.
module complement_unit_seq
  import complement_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  complement_unit_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  state_e state, state_nx;

  logic [NCHUNK-1:0][CHUNK-1:0] a_q, y_q, y_nx;
  logic [1:0]      mode_q;
  logic            inv_q, carry_q;
  logic [IDXW-1:0] idx_q;
  logic            zero_q, ovf_q;

  logic             in_ready_c, out_valid_c;
  logic             accept, last;
  logic             inv_in, cin_in;
  logic [CHUNK-1:0] cs_s;
  logic             cs_cout;
  logic             zero_nx, ovf_nx;

  assign accept = bus.in_valid && in_ready_c;
  assign last   = (idx_q == LAST);

  complement_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (a_q[idx_q]),
    .inv  (inv_q),
    .cin  (carry_q),
    .s    (cs_s),
    .cout (cs_cout)
  );

  // Mode decode into inversion and initial carry; ABS keys off the incoming sign.
  always_comb begin
    inv_in = 1'b0;
    cin_in = 1'b0;
    case (bus.mode)
      MODE_NOT: inv_in = 1'b1;
      MODE_NEG: begin inv_in = 1'b1; cin_in = 1'b1; end
      MODE_ABS: begin inv_in = bus.a[WIDTH-1]; cin_in = bus.a[WIDTH-1]; end
      default:  ;
    endcase
  end

  // Result with the current slice merged in, plus flags taken from it on the last slice.
  always_comb begin
    y_nx        = y_q;
    y_nx[idx_q] = cs_s;
    zero_nx     = (y_nx == '0);
    ovf_nx      = ((mode_q == MODE_NEG) || (mode_q == MODE_ABS)) &&
                  a_q[NCHUNK-1][CHUNK-1] && y_nx[NCHUNK-1][CHUNK-1];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE:    in_ready_c  = 1'b1;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, one slice per BUSY cycle, hold through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      y_q     <= '0;
      mode_q  <= MODE_NOT;
      inv_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q     <= bus.a;
          mode_q  <= bus.mode;
          inv_q   <= inv_in;
          carry_q <= cin_in;
          idx_q   <= '0;
        end
        BUSY: begin
          y_q     <= y_nx;
          carry_q <= cs_cout;
          idx_q   <= idx_q + IDXW'(1);
          if (last) begin
            zero_q <= zero_nx;
            ovf_q  <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule
